// File: rtl/dla_vpsignext_acc.sv
// Sign-extending packet accumulator: widens packed 16-bit or dual 8-bit signed lanes by
// guard bits, sums a packet of beats lane-wise and presents the result on a valid/ready register.
package dla_vpsignext_pkg;
  typedef enum logic [1:0] {
    PRECISION_IFMAP_8     = 2'd0,
    PRECISION_IFMAP_16    = 2'd1,
    PRECISION_IFMAP_RSVD2 = 2'd2,
    PRECISION_IFMAP_RSVD3 = 2'd3
  } precision_ifmap_e;
endpackage

module dla_vpsignext_acc
  import dla_vpsignext_pkg::*;
#(
  parameter int GRAN = 8,
  parameter int SAT  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  precision_ifmap_e          mode_precision,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [GRAN*2-1:0]         in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [(GRAN+SAT)*2-1:0]   out_data,
  output logic [1:0]                out_ovf
);
  localparam int IW = 2 * GRAN;
  localparam int LW = GRAN + SAT;
  localparam int OW = 2 * LW;

  logic [OW-1:0]    acc_q, acc_d;
  logic [1:0]       ovf_q, ovf_d;
  logic             first_q, first_d;
  precision_ifmap_e mode_q, mode_d;
  logic [OW-1:0]    out_data_q, out_data_d;
  logic [1:0]       out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  precision_ifmap_e eff_mode;
  logic [OW-1:0]    ext;
  logic [OW-1:0]    sum_w;
  logic [LW-1:0]    sum_hi, sum_lo;
  logic [OW-1:0]    acc_nxt;
  logic [1:0]       ovf_new;

  assign in_ready = !(out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;
  // The first beat of a packet already runs in the mode it is about to latch.
  assign eff_mode = first_q ? mode_precision : mode_q;

  always_comb begin
    case (eff_mode)
      PRECISION_IFMAP_16: ext = {{(2*SAT){in_data[IW-1]}}, in_data};
      PRECISION_IFMAP_8:  ext = {{SAT{in_data[IW-1]}}, in_data[IW-1:GRAN],
                                 {SAT{in_data[GRAN-1]}}, in_data[GRAN-1:0]};
      default:            ext = '0;
    endcase
  end

  always_comb begin
    sum_w   = acc_q + ext;
    sum_hi  = acc_q[OW-1:LW] + ext[OW-1:LW];
    sum_lo  = acc_q[LW-1:0] + ext[LW-1:0];
    acc_nxt = acc_q;
    ovf_new = '0;
    case (eff_mode)
      PRECISION_IFMAP_16: begin
        acc_nxt    = sum_w;
        ovf_new[1] = (acc_q[OW-1] == ext[OW-1]) && (sum_w[OW-1] != acc_q[OW-1]);
      end
      PRECISION_IFMAP_8: begin
        acc_nxt    = {sum_hi, sum_lo};
        ovf_new[1] = (acc_q[OW-1] == ext[OW-1]) && (sum_hi[LW-1] != acc_q[OW-1]);
        ovf_new[0] = (acc_q[LW-1] == ext[LW-1]) && (sum_lo[LW-1] != acc_q[LW-1]);
      end
      default: ;
    endcase
  end

  // NOTE: every *_d gets a hold default before any branch so no latch can be inferred.
  always_comb begin
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    first_d     = first_q;
    mode_d      = mode_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept) begin
      if (first_q) begin
        acc_d  = ext;
        ovf_d  = '0;
        mode_d = mode_precision;
      end else begin
        acc_d = acc_nxt;
        ovf_d = ovf_q | ovf_new;
      end
      first_d = in_last;
      // NOTE: blocking assignments here let the completion path reuse acc_d/ovf_d
      // computed just above, so the last beat is included without an extra cycle.
      if (in_last) begin
        out_data_d  = acc_d;
        out_ovf_d   = ovf_d;
        out_valid_d = 1'b1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      ovf_q       <= '0;
      first_q     <= 1'b1;
      mode_q      <= PRECISION_IFMAP_16;
      out_data_q  <= '0;
      out_ovf_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      first_q     <= first_d;
      mode_q      <= mode_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_dla_vpsignext_acc.sv
// Bench for dla_vpsignext_acc: vector table, hand-written handshake/reset sequences,
// and randomized traffic against an integer-arithmetic lane model.
module tb_dla_vpsignext_acc;
  import dla_vpsignext_pkg::*;

  localparam int G  = 8;
  localparam int S  = 1;
  localparam int IW = 2 * G;
  localparam int OW = 2 * (G + S);

  logic             clk = 1'b0;
  logic             rst_n;
  precision_ifmap_e mode_precision;
  logic             in_valid, in_ready, in_last;
  logic [IW-1:0]    in_data;
  logic             out_valid, out_ready;
  logic [OW-1:0]    out_data;
  logic [1:0]       out_ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dla_vpsignext_acc #(.GRAN(G), .SAT(S)) dut (
    .clk(clk), .rst_n(rst_n), .mode_precision(mode_precision),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  typedef struct {
    string            name;
    precision_ifmap_e mode;
    logic [15:0]      data;
    int               beats;
    logic [17:0]      exp_data;
    logic [1:0]       exp_ovf;
  } vec_t;

  vec_t vecs[10];
  logic [19:0] exp_q[$];

  // Reference lane state: plain signed integers, wrapped to the lane width after each add.
  int               m_hi, m_lo;
  bit               m_ov1, m_ov0;
  bit               m_first;
  precision_ifmap_e m_mode;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input precision_ifmap_e m, input logic [15:0] d, input logic l);
    int n;
    n = 0;
    mode_precision = m;
    in_data        = d;
    in_last        = l;
    in_valid       = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  function automatic int wrapw(input int v, input int w);
    int span, r;
    span = 1 << w;
    r = v % span;
    if (r >= span / 2) r -= span;
    if (r < -(span / 2)) r += span;
    return r;
  endfunction

  task automatic model_beat(input precision_ifmap_e md, input logic [15:0] d, input logic l);
    int e_hi, e_lo, w, t;
    logic [17:0] packed_res;
    if (m_first) m_mode = md;
    w = (m_mode == PRECISION_IFMAP_8) ? 9 : 18;
    e_hi = 0;
    e_lo = 0;
    if (m_mode == PRECISION_IFMAP_16) begin
      e_hi = int'($signed(d));
    end else if (m_mode == PRECISION_IFMAP_8) begin
      e_hi = int'($signed(d[15:8]));
      e_lo = int'($signed(d[7:0]));
    end
    if (m_first) begin
      m_hi = e_hi; m_lo = e_lo; m_ov1 = 1'b0; m_ov0 = 1'b0;
    end else begin
      t = m_hi + e_hi;
      if (t != wrapw(t, w)) m_ov1 = 1'b1;
      m_hi = wrapw(t, w);
      t = m_lo + e_lo;
      if (t != wrapw(t, w)) m_ov0 = 1'b1;
      m_lo = wrapw(t, w);
    end
    m_first = l;
    if (l) begin
      if (m_mode == PRECISION_IFMAP_8) packed_res = 18'(((m_hi & 511) << 9) | (m_lo & 511));
      else                             packed_res = 18'(m_hi & 32'h3FFFF);
      exp_q.push_back({m_ov1, m_ov0, packed_res});
    end
  endtask

  initial begin
    logic [19:0] e;
    logic        exp_ready, exp_valid;
    int          r;

    vecs[0] = '{"s16_8000",     PRECISION_IFMAP_16,    16'h8000, 1, 18'h38000, 2'b00};
    vecs[1] = '{"s8_807F",      PRECISION_IFMAP_8,     16'h807F, 1, 18'h3007F, 2'b00};
    vecs[2] = '{"ovf8_7F7Fx3",  PRECISION_IFMAP_8,     16'h7F7F, 3, 18'h2FB7D, 2'b11};
    vecs[3] = '{"w16_7FFFx4",   PRECISION_IFMAP_16,    16'h7FFF, 4, 18'h1FFFC, 2'b00};
    vecs[4] = '{"ovf16_7FFFx5", PRECISION_IFMAP_16,    16'h7FFF, 5, 18'h27FFB, 2'b10};
    vecs[5] = '{"neg8_8080x2",  PRECISION_IFMAP_8,     16'h8080, 2, 18'h20100, 2'b00};
    vecs[6] = '{"ovf8_8080x3",  PRECISION_IFMAP_8,     16'h8080, 3, 18'h10080, 2'b11};
    vecs[7] = '{"mix8_7F80x3",  PRECISION_IFMAP_8,     16'h7F80, 3, 18'h2FA80, 2'b11};
    vecs[8] = '{"rsvd_x2",      PRECISION_IFMAP_RSVD2, 16'h1234, 2, 18'h00000, 2'b00};
    vecs[9] = '{"neg16_FFFFx3", PRECISION_IFMAP_16,    16'hFFFF, 3, 18'h3FFFD, 2'b00};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    mode_precision = PRECISION_IFMAP_16;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      for (int b = 0; b < vecs[i].beats; b++)
        send(vecs[i].mode, vecs[i].data, b == vecs[i].beats - 1);
      check({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
      check({vecs[i].name, "_data"},  32'(out_data),  32'(vecs[i].exp_data));
      check({vecs[i].name, "_ovf"},   32'(out_ovf),   32'(vecs[i].exp_ovf));
    end
    step();
    check("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: result held and input blocked while downstream stalls.
    out_ready = 1'b0;
    send(PRECISION_IFMAP_16, 16'h0005, 1'b1);
    check("bp_first_data", 32'(out_data), 32'h5);
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data",  32'(out_data),  32'h5);
    end
    out_ready = 1'b1;
    send(PRECISION_IFMAP_16, 16'h0001, 1'b1);
    check("bp_release_valid", 32'(out_valid), 32'd1);
    check("bp_release_data",  32'(out_data),  32'h1);
    step();
    check("bp_drop_valid", 32'(out_valid), 32'd0);
    check("bp_hold_data",  32'(out_data),  32'h1);

    // Mode change mid-packet is ignored.
    send(PRECISION_IFMAP_8,  16'h0101, 1'b0);
    send(PRECISION_IFMAP_16, 16'h0101, 1'b1);
    check("modechg_data", 32'(out_data), 32'h00402);
    check("modechg_ovf",  32'(out_ovf),  32'd0);

    // Back-to-back single-beat packets with no bubble.
    send(PRECISION_IFMAP_16, 16'h0010, 1'b1);
    check("b2b_first", 32'(out_data), 32'h10);
    send(PRECISION_IFMAP_16, 16'h0020, 1'b1);
    check("b2b_second_valid", 32'(out_valid), 32'd1);
    check("b2b_second_data",  32'(out_data),  32'h20);
    step();

    // Reset mid-packet discards the partial sum.
    send(PRECISION_IFMAP_16, 16'h0005, 1'b0);
    send(PRECISION_IFMAP_16, 16'h0005, 1'b0);
    rst_n = 1'b0;
    #3;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data",  32'(out_data),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    send(PRECISION_IFMAP_16, 16'h0003, 1'b1);
    check("midrst_new_valid", 32'(out_valid), 32'd1);
    check("midrst_new_data",  32'(out_data),  32'h3);
    step();

    // Randomized traffic against the lane model.
    m_first = 1'b1;
    m_mode  = PRECISION_IFMAP_16;
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 2) == 0);
      in_data   = 16'($urandom);
      r = $urandom_range(0, 9);
      mode_precision = (r < 5) ? PRECISION_IFMAP_8 :
                       (r < 9) ? PRECISION_IFMAP_16 : PRECISION_IFMAP_RSVD2;
      #1;
      exp_valid = (exp_q.size() > 0);
      exp_ready = !(exp_valid && !out_ready);
      check("rnd_in_ready",  32'(in_ready),  32'(exp_ready));
      check("rnd_out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) begin
        e = exp_q[0];
        check("rnd_out_data", 32'(out_data), 32'(e[17:0]));
        check("rnd_out_ovf",  32'(out_ovf),  32'(e[19:18]));
        if (out_ready) void'(exp_q.pop_front());
      end
      if (in_valid && exp_ready) model_beat(mode_precision, in_data, in_last);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dla_vpsignext_acc.md
Name: dla_vpsignext_acc

Overview:
- Widening counterpart of the KPE sign-saturation narrowing stage.
- Accepts packed signed ifmap-precision words (GRAN*2 bits: one 16-bit lane or two 8-bit lanes), sign-extends each lane by SAT guard bits and accumulates a packet of beats in guard-bit-wide lanes.
- Emits the (GRAN+SAT)*2-bit packed result through a valid/ready output register, in the exact packed format the sign-saturation stage consumes.
- Sits between the kernel PE product path and the saturation/requantisation stage.

Parameters:
- GRAN, 8, lane granularity in bits; an 8-bit lane is GRAN bits and a 16-bit lane is 2*GRAN bits.
- SAT, 1, guard bits added per narrow lane; 2*SAT guard bits in 16-bit mode.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- mode_precision  input  precision_ifmap_e  lane mode; sampled on the first beat of each packet
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid && in_ready
- in_data  input  GRAN*2  packed signed lanes
- in_last  input  1  final beat of the packet
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_data  output  (GRAN+SAT)*2  packed signed accumulated lanes
- out_ovf  output  2  sticky per-lane signed-overflow flags for the packet

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_ovf=0, acc=0, ovf=0, first=1, latched mode=PRECISION_IFMAP_16.
- Ready rule: in_ready = !(out_valid && !out_ready). This is combinational from out_ready; there is no in_valid->in_ready path.
- Throughput is one beat per cycle while unstalled.
- Sign extension, PRECISION_IFMAP_16: ext = {2*SAT copies of in_data[2G-1], in_data}, treated as one lane of 2(G+S) bits.
- Sign extension, PRECISION_IFMAP_8: hi = {SAT copies of in_data[2G-1], in_data[2G-1:G]} and lo = {SAT copies of in_data[G-1], in_data[G-1:0]}; ext = {hi, lo}.
- Sign extension, any other mode: ext = 0. Beats are still consumed, and ovf never sets.
- Accumulate, per accepted beat: if first, acc <= ext and ovf <= 0; otherwise acc <= acc + ext, computed lane-wise.
- In 8-bit mode the two lanes are independent (G+S)-bit adds, with no carry across the lane boundary.
- Addition wraps modulo the lane width.
- Signed overflow (operand signs equal, result sign differs) sets the lane's ovf bit. ovf[1] is the 16-bit lane or the hi 8-bit lane; ovf[0] is the lo 8-bit lane and is always 0 in 16-bit mode.
- Mode latch: mode_precision is latched when first=1 and a beat is accepted. Changes mid-packet are ignored until the next packet.
- first: cleared on any accepted beat with in_last=0; set on any accepted beat with in_last=1.
- Completion: on an accepted beat with in_last=1, the next cycle has out_valid=1, out_data = final accumulated value (including that beat), and out_ovf = final ovf.
- A single-beat packet (first && last) outputs ext.
- acc and ovf are not cleared until the next first beat, so they need no extra cycle.
- Latency: 1 cycle from the last beat to out_valid.
- Output handshake: while out_valid && !out_ready, out_data and out_ovf are held stable and in_ready=0.
- out_valid && out_ready with no new last beat: out_valid <= 0 next cycle and out_data holds its value.
- out_valid && out_ready together with a new accepted last beat: out_valid stays 1 and out_data updates to the new result (back-to-back packets, no bubble).
- Reset mid-packet discards the partial accumulation and any pending output, and the next accepted beat starts a new packet.
- Implementation: flops are acc, ovf, first, latched mode, out_data, out_ovf and out_valid; there is no FSM beyond the first flag and the out_valid flag.

Test Plan (GRAN=8, SAT=1):
- 16-bit single beat: in_data=16'h8000, last -> next cycle out_valid=1, out_data=18'h38000, out_ovf=2'b00.
- 8-bit single beat: in_data=16'h807F, last -> out_data=18'h3007F ({9'h180, 9'h07F}), out_ovf=0.
- 8-bit overflow: three beats of 16'h7F7F, last on the third -> out_data=18'h2FB7D (each lane 9'h17D, wrapped from 381), out_ovf=2'b11.
- Backpressure: hold out_ready=0 after a result -> in_ready=0 and out_data unchanged for 5 cycles. Raise out_ready together with a pending single-beat packet 16'h0001 (mode 16) -> next cycle out_valid=1, out_data=18'h00001.
- Mode change mid-packet: first beat 16'h0101 in mode 8, second beat 16'h0101 with mode_precision=16 and last -> out_data={9'h002, 9'h002}=18'h00402.
- Reset mid-packet: two non-last beats of 16'h0005 (mode 16), pulse rst_n low -> out_valid=0. Then a single last beat 16'h0003 -> out_data=18'h00003.
